// File: rtl/ppu_vram_arb.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | ppu_vram_arb: arbitrates ppumc between PPU fetch, debug and CPU PPUDATA  |
// | requesters. Define PPU_VRAM_ARB_STATS_EN to add the conflict_cnt port.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ppu_vram_arb #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dbg_hold,
    input  logic              ppu_req,
    input  logic [ADDR_W-1:0] ppu_a,
    output logic              ppu_gnt,
    output logic              ppu_rd_vld,
    input  logic              dbg_req,
    input  logic              dbg_wr,
    input  logic [ADDR_W-1:0] dbg_a,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rd_vld,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_a,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rd_vld,
    output logic [ADDR_W-1:0] mc_a,
    output logic              mc_wr,
    output logic [DATA_W-1:0] mc_din,
    input  logic [DATA_W-1:0] mc_dout,
    output logic [DATA_W-1:0] rd_data
`ifdef PPU_VRAM_ARB_STATS_EN
    ,
    output logic [15:0]       conflict_cnt
`endif
);

    localparam logic [7:0] c_starve_max = 8'(STARVE_MAX);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PPU_RD = 3'd1,
        S_DBG_RD = 3'd2,
        S_CPU_RD = 3'd3,
        S_WR     = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_rr;
    logic [7:0]        r_starve_cnt;
    logic [ADDR_W-1:0] r_last_a;

    logic w_lower_req;
    logic w_starved;
    logic w_ppu_gnt;
    logic w_dbg_gnt;
    logic w_cpu_gnt;

    // Grants are held low while reset is asserted so nothing reaches ppumc.
    always_comb begin
        w_ppu_gnt   = 1'b0;
        w_dbg_gnt   = 1'b0;
        w_cpu_gnt   = 1'b0;
        w_lower_req = dbg_req | cpu_req;
        w_starved   = (r_starve_cnt == c_starve_max) && w_lower_req;
        if (!rst) begin
            w_ppu_gnt = 1'b0;
        end else if (dbg_hold) begin
            w_dbg_gnt = dbg_req;
        end else if (ppu_req && !w_starved) begin
            w_ppu_gnt = 1'b1;
        end else if (dbg_req && (!cpu_req || !r_rr)) begin
            w_dbg_gnt = 1'b1;
        end else if (cpu_req) begin
            w_cpu_gnt = 1'b1;
        end
    end

    assign ppu_gnt = w_ppu_gnt;
    assign dbg_gnt = w_dbg_gnt;
    assign cpu_gnt = w_cpu_gnt;

    always_comb begin
        mc_a   = r_last_a;
        mc_wr  = 1'b0;
        mc_din = '0;
        if (w_ppu_gnt) begin
            mc_a = ppu_a;
        end else if (w_dbg_gnt) begin
            mc_a   = dbg_a;
            mc_wr  = dbg_wr;
            mc_din = dbg_wr ? dbg_wdata : '0;
        end else if (w_cpu_gnt) begin
            mc_a   = cpu_a;
            mc_wr  = cpu_wr;
            mc_din = cpu_wr ? cpu_wdata : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_rr         <= 1'b0;
            r_starve_cnt <= 8'd0;
            r_last_a     <= '0;
        end else begin
            if (w_ppu_gnt) begin
                r_state <= S_PPU_RD;
            end else if (w_dbg_gnt) begin
                r_state <= dbg_wr ? S_WR : S_DBG_RD;
            end else if (w_cpu_gnt) begin
                r_state <= cpu_wr ? S_WR : S_CPU_RD;
            end else begin
                r_state <= S_IDLE;
            end

            if (w_ppu_gnt || w_dbg_gnt || w_cpu_gnt) begin
                r_last_a <= mc_a;
            end

            // A debug break freezes fairness bookkeeping.
            if (!dbg_hold) begin
                if (w_dbg_gnt) begin
                    r_rr <= 1'b1;
                end else if (w_cpu_gnt) begin
                    r_rr <= 1'b0;
                end

                if (w_dbg_gnt || w_cpu_gnt || !w_lower_req) begin
                    r_starve_cnt <= 8'd0;
                end else if (w_ppu_gnt && (r_starve_cnt != c_starve_max)) begin
                    r_starve_cnt <= r_starve_cnt + 8'd1;
                end
            end
        end
    end

    assign ppu_rd_vld = (r_state == S_PPU_RD);
    assign dbg_rd_vld = (r_state == S_DBG_RD);
    assign cpu_rd_vld = (r_state == S_CPU_RD);
    assign rd_data    = (ppu_rd_vld | dbg_rd_vld | cpu_rd_vld) ? mc_dout : '0;

`ifdef PPU_VRAM_ARB_STATS_EN
    logic        w_conflict;
    logic [15:0] r_conflict_cnt;

    assign w_conflict = (ppu_req & ~w_ppu_gnt) | (dbg_req & ~w_dbg_gnt) |
                        (cpu_req & ~w_cpu_gnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_conflict_cnt <= 16'd0;
        end else if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ppu_vram_arb.sv
`default_nettype none
`timescale 1ns/1ps
// tb_ppu_vram_arb: directed and randomized stimulus against a reference
// arbitration model; read returns are checked from a scoreboard queue.
module tb_ppu_vram_arb;

    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 8;
    localparam int STARVE_MAX = 8;
    localparam int W_NONE = 0, W_PPU = 1, W_DBG = 2, W_CPU = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              dbg_hold = 1'b0;
    logic              ppu_req = 1'b0;
    logic [ADDR_W-1:0] ppu_a = '0;
    logic              ppu_gnt, ppu_rd_vld;
    logic              dbg_req = 1'b0, dbg_wr = 1'b0;
    logic [ADDR_W-1:0] dbg_a = '0;
    logic [DATA_W-1:0] dbg_wdata = '0;
    logic              dbg_gnt, dbg_rd_vld;
    logic              cpu_req = 1'b0, cpu_wr = 1'b0;
    logic [ADDR_W-1:0] cpu_a = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_gnt, cpu_rd_vld;
    logic [ADDR_W-1:0] mc_a;
    logic              mc_wr;
    logic [DATA_W-1:0] mc_din;
    logic [DATA_W-1:0] mc_dout;
    logic [DATA_W-1:0] rd_data;
`ifdef PPU_VRAM_ARB_STATS_EN
    logic [15:0]       conflict_cnt;
`endif

    ppu_vram_arb #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dbg_hold  (dbg_hold),
        .ppu_req   (ppu_req),
        .ppu_a     (ppu_a),
        .ppu_gnt   (ppu_gnt),
        .ppu_rd_vld(ppu_rd_vld),
        .dbg_req   (dbg_req),
        .dbg_wr    (dbg_wr),
        .dbg_a     (dbg_a),
        .dbg_wdata (dbg_wdata),
        .dbg_gnt   (dbg_gnt),
        .dbg_rd_vld(dbg_rd_vld),
        .cpu_req   (cpu_req),
        .cpu_wr    (cpu_wr),
        .cpu_a     (cpu_a),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_rd_vld(cpu_rd_vld),
        .mc_a      (mc_a),
        .mc_wr     (mc_wr),
        .mc_din    (mc_din),
        .mc_dout   (mc_dout),
        .rd_data   (rd_data)
`ifdef PPU_VRAM_ARB_STATS_EN
        ,
        .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ppumc stand-in: one-cycle synchronous read, write on mc_wr.
    logic [7:0] mem     [0:16383];
    logic [7:0] ref_mem [0:16383];
    always @(posedge clk) begin
        if (mc_wr) mem[mc_a] <= mc_din;
        mc_dout <= mem[mc_a];
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         due;
        int         who;
        logic [7:0] data;
    } rd_exp_t;
    rd_exp_t sb[$];

    int          last_who = W_NONE;
    logic [7:0]  last_rd = '0;
    logic [2:0]  obs_g;
    int          exp_g;
    int          m_rr = 0;
    int          m_starve = 0;
    logic [13:0] m_last_a = '0;

    function automatic logic [2:0] onehot(input int w);
        case (w)
            W_PPU:   return 3'b100;
            W_DBG:   return 3'b010;
            W_CPU:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_rr     = 0;
        m_starve = 0;
        m_last_a = '0;
    endtask

    // Reference arbitration: predicts this cycle's winner and ppumc access.
    task automatic model_step();
        int          g;
        logic        lower;
        logic [13:0] ea;
        logic        ew;
        logic [7:0]  ed;
        lower = dbg_req | cpu_req;
        if (dbg_hold)                                        g = dbg_req ? W_DBG : W_NONE;
        else if (ppu_req && !(m_starve >= STARVE_MAX && lower)) g = W_PPU;
        else if (dbg_req && cpu_req)                         g = (m_rr == 1) ? W_CPU : W_DBG;
        else if (dbg_req)                                    g = W_DBG;
        else if (cpu_req)                                    g = W_CPU;
        else                                                 g = W_NONE;

        obs_g = {ppu_gnt, dbg_gnt, cpu_gnt};
        check("gnt", 32'(obs_g), 32'(onehot(g)));

        ea = m_last_a; ew = 1'b0; ed = '0;
        case (g)
            W_PPU: ea = ppu_a;
            W_DBG: begin ea = dbg_a; ew = dbg_wr; ed = dbg_wr ? dbg_wdata : 8'h00; end
            W_CPU: begin ea = cpu_a; ew = cpu_wr; ed = cpu_wr ? cpu_wdata : 8'h00; end
            default: ;
        endcase
        check("mc_a", 32'(mc_a), 32'(ea));
        check("mc_wr", 32'(mc_wr), 32'(ew));
        if (ew || g == W_NONE) check("mc_din", 32'(mc_din), 32'(ed));

        if (g != W_NONE) begin
            m_last_a = ea;
            if (ew) ref_mem[ea] = ed;
            else    sb.push_back('{cyc + 1, g, ref_mem[ea]});
        end
        if (!dbg_hold) begin
            if (g == W_DBG)      m_rr = 1;
            else if (g == W_CPU) m_rr = 0;
            if (g == W_DBG || g == W_CPU || !lower)     m_starve = 0;
            else if (g == W_PPU && m_starve < STARVE_MAX) m_starve++;
        end
        exp_g = g;
    endtask

    // Called at a falling edge with inputs driven; returns at the next one.
    task automatic step();
        #1;
        model_step();
        @(negedge clk);
        case (exp_g)
            W_PPU: ppu_req = 1'b0;
            W_DBG: dbg_req = 1'b0;
            W_CPU: cpu_req = 1'b0;
            default: ;
        endcase
    endtask

    function automatic logic [13:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 14'($urandom);
        return 14'h3F00 | 14'($urandom_range(0, 7));
    endfunction

    logic [2:0] mon_vld;
    rd_exp_t    mon_e;
    always @(negedge clk) begin
        if (rst) begin
            mon_vld = {ppu_rd_vld, dbg_rd_vld, cpu_rd_vld};
            checks++;
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                mon_e = sb.pop_front();
                if (mon_vld !== onehot(mon_e.who) || rd_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL rd_return: vld=%b data=%h, expected vld=%b data=%h (cycle %0d)",
                             mon_vld, rd_data, onehot(mon_e.who), mon_e.data, cyc);
                end
                last_who = mon_e.who;
                last_rd  = rd_data;
            end else if (mon_vld !== 3'b000) begin
                errors++;
                $display("FAIL rd_unexpected: vld=%b, expected 000 (cycle %0d)", mon_vld, cyc);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    int first_cpu;

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end

        // Reset state: requests present but nothing may be granted.
        rst = 1'b0; dbg_req = 1'b1; dbg_a = 14'h1234; ppu_req = 1'b1; cpu_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_ctl", 32'({ppu_gnt, dbg_gnt, cpu_gnt, ppu_rd_vld, dbg_rd_vld, cpu_rd_vld, mc_wr}), 32'd0);
        check("reset_mc_a", 32'(mc_a), 32'd0);
        check("reset_mc_din", 32'(mc_din), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        ppu_req = 1'b0; dbg_req = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();

`ifdef PPU_VRAM_ARB_STATS_EN
        ppu_a = 14'h0010; cpu_a = 14'h0020; cpu_wr = 1'b0; cpu_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ppu_req = 1'b1;
            step();
        end
        #1;
        check("conflict_cnt", 32'(conflict_cnt), 32'd4);
        ppu_req = 1'b0; cpu_req = 1'b0;
        step();
`endif

        // Round robin from rr=0.
        dbg_wr = 1'b0; cpu_wr = 1'b0; dbg_a = 14'h0400; cpu_a = 14'h0401;
        for (int i = 0; i < 4; i++) begin
            dbg_req = 1'b1; cpu_req = 1'b1;
            step();
            check("rr_order", 32'(obs_g), (i % 2 == 0) ? 32'(3'b010) : 32'(3'b001));
        end
        dbg_req = 1'b0; cpu_req = 1'b0;
        step();

        // Basic read latency.
        mem[14'h23C0] = 8'hA5; ref_mem[14'h23C0] = 8'hA5;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_a = 14'h23C0;
        #1;
        check("cpu_rd_mc_a", 32'(mc_a), 32'h23C0);
        #1;
        step();
        #2;
        check("cpu_rd_who", 32'(last_who), 32'(W_CPU));
        check("cpu_rd_data", 32'(last_rd), 32'hA5);

        // Starvation: twice to show the counter restarts after the cpu grant.
        step();
        ppu_a = 14'h0100; cpu_a = 14'h0200; cpu_wr = 1'b0;
        for (int r = 0; r < 2; r++) begin
            first_cpu = -1;
            cpu_req = 1'b1;
            for (int i = 0; i < 20 && first_cpu < 0; i++) begin
                ppu_req = 1'b1;
                step();
                if (obs_g == 3'b001) first_cpu = i;
            end
            check("starve_slot", 32'(first_cpu), 32'(STARVE_MAX));
        end
        ppu_req = 1'b1;
        step();
        check("starve_ppu_resume", 32'(obs_g), 32'(3'b100));

        // Debug hold: only debug is served; write then read back.
        dbg_hold = 1'b1;
        ppu_req = 1'b1; ppu_a = 14'h0300;
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_a = 14'h3F00; cpu_wdata = 8'h11;
        dbg_req = 1'b1; dbg_wr = 1'b1; dbg_a = 14'h3F00; dbg_wdata = 8'h3F;
        step();
        check("hold_dbg_wr", 32'(obs_g), 32'(3'b010));
        dbg_req = 1'b1; dbg_wr = 1'b0;
        step();
        check("hold_dbg_rd", 32'(obs_g), 32'(3'b010));
        #2;
        check("hold_readback", 32'(last_rd), 32'h3F);
        check("hold_readback_who", 32'(last_who), 32'(W_DBG));
        step();
        check("hold_blocks", 32'(obs_g), 32'(3'b000));
        dbg_hold = 1'b0;
        step();
        check("hold_release_ppu", 32'(obs_g), 32'(3'b100));
        step();
        check("hold_release_cpu", 32'(obs_g), 32'(3'b001));

        // Reset asserted right after a debug read grant.
        dbg_req = 1'b1; dbg_wr = 1'b0; dbg_a = 14'h2000;
        #1;
        model_step();
        check("rst_mid_gnt", 32'(obs_g), 32'(3'b010));
        @(posedge clk);
        rst = 1'b0;
        sb.delete();
        dbg_req = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        check("rst_mid_ctl", 32'({ppu_gnt, dbg_gnt, cpu_gnt, ppu_rd_vld, dbg_rd_vld, cpu_rd_vld, mc_wr}), 32'd0);
        check("rst_mid_mc_a", 32'(mc_a), 32'd0);
        check("rst_mid_mc_din", 32'(mc_din), 32'd0);
        check("rst_mid_rd_data", 32'(rd_data), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        step();
        check("rst_mid_no_vld", 32'(dbg_rd_vld), 32'd0);
        step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (!ppu_req && $urandom_range(0, 99) < 85) begin
                ppu_req = 1'b1; ppu_a = rand_addr();
            end
            if (!dbg_req && $urandom_range(0, 99) < 25) begin
                dbg_req = 1'b1; dbg_wr = 1'($urandom_range(0, 1));
                dbg_a = rand_addr(); dbg_wdata = 8'($urandom);
            end
            if (!cpu_req && $urandom_range(0, 99) < 35) begin
                cpu_req = 1'b1; cpu_wr = 1'($urandom_range(0, 1));
                cpu_a = rand_addr(); cpu_wdata = 8'($urandom);
            end
            if ($urandom_range(0, 99) < 3) dbg_hold = ~dbg_hold;
            step();
        end

        dbg_hold = 1'b0; ppu_req = 1'b0; dbg_req = 1'b0; cpu_req = 1'b0;
        step();
        step();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
